// File: rtl/if_id_queue_pkg.sv
// Shared constants for the IF/ID instruction queue.
package if_id_queue_pkg;

  localparam logic RstEnable = 1'b1;
  localparam logic ENABLE    = 1'b1;
  localparam logic DISABLE   = 1'b0;

  localparam int unsigned StallW   = 6;
  localparam int unsigned STALL_IF = 1;
  localparam int unsigned STALL_ID = 2;

  localparam int unsigned InsAddrWidth = 32;
  localparam int unsigned InsWidth     = 32;

  localparam logic [InsWidth-1:0] ZeroWord = '0;
  localparam logic [InsWidth-1:0] NopIns   = '0;

endpackage : if_id_queue_pkg

// File: rtl/if_id_queue_mem.sv
// Queue storage: DEPTH x W register array, one sync write port, one async read port.
module if_id_queue_mem #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 64,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [DEPTH];

  // Write port; contents are not reset since occupancy is tracked separately.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule : if_id_queue_mem

// File: rtl/if_id_queue.sv
// DEPTH-entry instruction queue between IF and ID with valid/ready intake,
// stall-gated consumption and branch-redirect flush. DEPTH: power of two, >= 2.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int unsigned       ADDR_W  = InsAddrWidth,
  parameter int unsigned       INS_W   = InsWidth,
  parameter int unsigned       DEPTH   = 4,
  parameter logic [INS_W-1:0]  NOP_INS = INS_W'(NopIns),
  localparam int unsigned      PTR_W   = $clog2(DEPTH),
  localparam int unsigned      CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic [INS_W-1:0]  if_ins,
  output logic              if_ready,
  input  logic [StallW-1:0] stall,
  input  logic              flush,
  output logic              id_valid,
  output logic [ADDR_W-1:0] id_pc,
  output logic [INS_W-1:0]  id_ins,
  output logic [CNT_W-1:0]  id_count
);

  localparam int unsigned EntryW = ADDR_W + INS_W;

  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic              w_full;
  logic              w_push;
  logic              w_pop;
  logic [EntryW-1:0] w_rd_data;
  logic [4:0]        w_unused_stall;

  // Only the ID hold bit matters here; IF honours its own stall upstream.
  assign w_unused_stall = {stall[5:3], stall[STALL_IF], stall[0]};

  // Handshake status comes from registered occupancy only.
  assign w_full   = (r_count == CNT_W'(DEPTH));
  assign if_ready = w_full ? DISABLE : ENABLE;
  assign id_valid = (r_count != '0) ? ENABLE : DISABLE;
  assign id_count = r_count;

  // Flush suppresses both events so the redirect leaves a clean bubble.
  assign w_push = if_valid & ~w_full & ~flush;
  assign w_pop  = id_valid & ~stall[STALL_ID] & ~flush;

  // Pointer and occupancy update; flush outranks everything but reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  if_id_queue_mem #(
    .DEPTH (DEPTH),
    .W     (EntryW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata ({if_pc, if_ins}),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rd_data)
  );

  // Present the head entry, or a NOP bubble when nothing is queued.
  always_comb begin
    id_pc  = ADDR_W'(ZeroWord);
    id_ins = NOP_INS;
    if (id_valid == ENABLE) begin
      id_pc  = w_rd_data[INS_W +: ADDR_W];
      id_ins = w_rd_data[INS_W-1:0];
    end
  end

endmodule : if_id_queue

// File: tb/tb_if_id_queue.sv
// Directed self-checking bench for if_id_queue (default DEPTH=4).
`timescale 1ns/1ps
module tb_if_id_queue;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned INS_W  = 32;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
  localparam logic [INS_W-1:0] NOP = 32'h0000_0000;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              if_valid = 1'b0;
  logic [ADDR_W-1:0] if_pc = '0;
  logic [INS_W-1:0]  if_ins = '0;
  logic              if_ready;
  logic [5:0]        stall = '0;
  logic              flush = 1'b0;
  logic              id_valid;
  logic [ADDR_W-1:0] id_pc;
  logic [INS_W-1:0]  id_ins;
  logic [CNT_W-1:0]  id_count;

  int n_checks = 0;
  int n_fail   = 0;

  if_id_queue #(
    .ADDR_W  (ADDR_W),
    .INS_W   (INS_W),
    .DEPTH   (DEPTH),
    .NOP_INS (NOP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .if_valid (if_valid),
    .if_pc    (if_pc),
    .if_ins   (if_ins),
    .if_ready (if_ready),
    .stall    (stall),
    .flush    (flush),
    .id_valid (id_valid),
    .id_pc    (id_pc),
    .id_ins   (id_ins),
    .id_count (id_count)
  );

  always #5 clk = ~clk;

  // Advance to 1ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one instruction for exactly one edge.
  task automatic push_one(input logic [31:0] pc, input logic [31:0] ins);
    if_valid = 1'b1;
    if_pc    = pc;
    if_ins   = ins;
    tick();
    if_valid = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", id_valid); end
    n_checks++; if (id_count !== 3'd0) begin n_fail++; $display("FAIL rst_count: got %0d want 0", id_count); end
    n_checks++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", if_ready); end
    n_checks++; if (id_pc !== 32'h0 || id_ins !== NOP) begin n_fail++; $display("FAIL rst_bubble: got pc=%h ins=%h want 0/%h", id_pc, id_ins, NOP); end
    tick();
    rst = 1'b0;
    tick();
    // Mid-stream: fill three entries, then reset between edges.
    stall[2] = 1'b1;
    push_one(32'h0000_0A00, 32'hA000_0001);
    push_one(32'h0000_0A04, 32'hA000_0002);
    push_one(32'h0000_0A08, 32'hA000_0003);
    n_checks++; if (id_count !== 3'd3) begin n_fail++; $display("FAIL pre_rst_count: got %0d want 3", id_count); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b want 0", id_valid); end
    n_checks++; if (id_count !== 3'd0) begin n_fail++; $display("FAIL midrst_count: got %0d want 0", id_count); end
    n_checks++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b want 1", if_ready); end
    n_checks++; if (id_ins !== NOP || id_pc !== 32'h0) begin n_fail++; $display("FAIL midrst_bubble: got pc=%h ins=%h want 0/%h", id_pc, id_ins, NOP); end
    tick();
    rst = 1'b0;
    stall = '0;
    tick();
  endtask

  task automatic test_fill_drain();
    stall[2] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      push_one(32'(4 * k), 32'h1000_0000 + 32'(4 * k));
      n_checks++; if (id_count !== 3'(k + 1)) begin n_fail++; $display("FAIL fill_count[%0d]: got %0d want %0d", k, id_count, k + 1); end
    end
    n_checks++; if (if_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b want 0", if_ready); end
    push_one(32'h10, 32'h1000_0010);
    n_checks++; if (id_count !== 3'd4) begin n_fail++; $display("FAIL full_refuse_count: got %0d want 4", id_count); end
    stall[2] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (id_valid !== 1'b1 || id_pc !== 32'(4 * k) || id_ins !== 32'h1000_0000 + 32'(4 * k)) begin
        n_fail++; $display("FAIL drain[%0d]: got v=%b pc=%h ins=%h want 1/%h/%h", k, id_valid, id_pc, id_ins, 4 * k, 32'h1000_0000 + 32'(4 * k));
      end
      tick();
    end
    n_checks++; if (id_valid !== 1'b0 || id_ins !== NOP || id_pc !== 32'h0) begin n_fail++; $display("FAIL drain_empty: got v=%b pc=%h ins=%h want 0/0/%h", id_valid, id_pc, id_ins, NOP); end
  endtask

  task automatic test_wrap();
    push_one(32'h100, 32'hB000_0100);
    for (int k = 0; k < 10; k++) begin
      if_valid = 1'b1;
      if_pc    = 32'h100 + 32'(4 * (k + 1));
      if_ins   = 32'hB000_0100 + 32'(4 * (k + 1));
      n_checks++;
      if (id_pc !== 32'h100 + 32'(4 * k) || id_ins !== 32'hB000_0100 + 32'(4 * k)) begin
        n_fail++; $display("FAIL wrap_order[%0d]: got pc=%h ins=%h want %h", k, id_pc, id_ins, 32'h100 + 32'(4 * k));
      end
      n_checks++; if (id_count !== 3'd1) begin n_fail++; $display("FAIL wrap_count[%0d]: got %0d want 1", k, id_count); end
      tick();
    end
    if_valid = 1'b0;
    n_checks++; if (id_pc !== 32'h128) begin n_fail++; $display("FAIL wrap_last: got %h want 128", id_pc); end
    tick();
    n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_empty: got %b want 0", id_valid); end
  endtask

  task automatic test_flush();
    stall[2] = 1'b1;
    push_one(32'h20, 32'hC000_0020);
    push_one(32'h24, 32'hC000_0024);
    push_one(32'h28, 32'hC000_0028);
    n_checks++; if (id_count !== 3'd3) begin n_fail++; $display("FAIL flush_pre_count: got %0d want 3", id_count); end
    flush = 1'b1;
    push_one(32'h200, 32'hC000_0200);
    flush = 1'b0;
    stall[2] = 1'b0;
    n_checks++; if (id_count !== 3'd0 || id_valid !== 1'b0) begin n_fail++; $display("FAIL flush_empty: got cnt=%0d v=%b want 0/0", id_count, id_valid); end
    n_checks++; if (id_pc !== 32'h0 || id_ins !== NOP) begin n_fail++; $display("FAIL flush_bubble: got pc=%h ins=%h want 0/%h", id_pc, id_ins, NOP); end
    push_one(32'h300, 32'hC000_0300);
    n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'h300 || id_count !== 3'd1) begin n_fail++; $display("FAIL flush_after: got v=%b pc=%h cnt=%0d want 1/300/1", id_valid, id_pc, id_count); end
    tick();
    n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL flush_drain: got %b want 0", id_valid); end
  endtask

  task automatic test_full_pop();
    stall[2] = 1'b1;
    for (int k = 0; k < 4; k++) push_one(32'h500 + 32'(4 * k), 32'hD000_0500 + 32'(4 * k));
    n_checks++; if (id_count !== 3'd4 || if_ready !== 1'b0) begin n_fail++; $display("FAIL fullpop_pre: got cnt=%0d rdy=%b want 4/0", id_count, if_ready); end
    stall[2] = 1'b0;
    push_one(32'h600, 32'hD000_0600);
    n_checks++; if (id_count !== 3'd3 || if_ready !== 1'b1) begin n_fail++; $display("FAIL fullpop_after: got cnt=%0d rdy=%b want 3/1", id_count, if_ready); end
    n_checks++; if (id_pc !== 32'h504) begin n_fail++; $display("FAIL fullpop_head: got %h want 504", id_pc); end
    tick();
    tick();
    n_checks++; if (id_pc !== 32'h50C || id_count !== 3'd1) begin n_fail++; $display("FAIL fullpop_tail: got pc=%h cnt=%0d want 50c/1", id_pc, id_count); end
    tick();
    n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL fullpop_refused: got v=%b pc=%h want 0", id_valid, id_pc); end
  endtask

  task automatic test_stall_hold();
    stall[2] = 1'b1;
    push_one(32'h40, 32'h8C22_0000);
    push_one(32'h44, 32'h8C23_0004);
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (id_valid !== 1'b1 || id_pc !== 32'h40 || id_ins !== 32'h8C22_0000) begin
        n_fail++; $display("FAIL stall_hold[%0d]: got v=%b pc=%h ins=%h want 1/40/8c220000", k, id_valid, id_pc, id_ins);
      end
      tick();
    end
    stall[2] = 1'b0;
    tick();
    n_checks++; if (id_pc !== 32'h44 || id_ins !== 32'h8C23_0004) begin n_fail++; $display("FAIL stall_resume: got pc=%h ins=%h want 44/8c230004", id_pc, id_ins); end
    tick();
    n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL stall_empty: got %b want 0", id_valid); end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_wrap();
    test_flush();
    test_full_pop();
    test_stall_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_if_id_queue
